// File: rtl/async_tx_buffered.sv
// async_tx_buffered: 8N1 UART transmitter fed from an internal byte FIFO.
// Queued bytes leave back-to-back on txd at a fractional-accumulator baud rate.
module async_tx_buffered #(
    parameter int clk_freq   = 25000000,
    parameter int baud       = 115200,
    parameter int fifo_depth = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       txd_start,
    input  logic [7:0] txd_data,
    output logic       txd_full,
    output logic       txd_busy,
    output logic       txd_overflow,
    output logic       txd
);

    localparam int ptr_w     = $clog2(fifo_depth);
    localparam int cnt_w     = ptr_w + 1;
    localparam int acc_width = $clog2(clk_freq / baud) + 8;

    // Rounded baud * 2^acc_width / clk_freq, computed as floor((2x + d) / 2d).
    localparam longint inc_calc =
        ((longint'(baud) << (acc_width + 1)) + longint'(clk_freq)) / (2 * longint'(clk_freq));

    typedef logic [acc_width:0] acc_t;
    localparam acc_t inc = acc_t'(inc_calc);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]       mem [fifo_depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    state_t           state;
    acc_t             acc;
    logic             tick;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;

    assign fifo_empty = (count == '0);
    assign txd_full   = (count == cnt_w'(fifo_depth));
    assign txd_busy   = (state != IDLE) || !fifo_empty;
    assign push       = txd_start && !txd_full;
    assign tick       = acc[acc_width];

    // The head is popped either to leave IDLE or straight out of STOP for gapless frames.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && tick));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= txd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            txd_overflow <= 1'b0;
        end else begin
            txd_overflow <= txd_start && txd_full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Accumulator is parked at inc in IDLE so the first tick lands one bit period after START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= inc;
            shreg   <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            if (state == IDLE) begin
                acc <= inc;
            end else begin
                acc <= {1'b0, acc[acc_width-1:0]} + inc;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/async_tx_buffered.md
# async_tx_buffered

UART transmitter with an internal byte FIFO: 8 data bits, LSB first, 1 stop bit, no parity. Host logic (MP3 decoder debug/status path) pushes bytes with a one-cycle strobe. The block serialises them back-to-back onto `txd` at the configured baud rate and forms the transmit end of the serial link whose receive end is the existing 8N1 receiver.

## Interface
- `clk_freq`, default 25000000: clock frequency in Hz.
- `baud`, default 115200: line rate in bit/s.
- `fifo_depth`, default 16: FIFO entries; power of 2, at least 2.

- `clk`  in  1  system clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `txd_start`  in  1  write strobe; pushes `txd_data` when `txd_full`=0.
- `txd_data`  in  8  byte to send; sampled when `txd_start`=1.
- `txd_full`  out  1  FIFO holds `fifo_depth` bytes.
- `txd_busy`  out  1  FIFO non-empty or a frame is in progress.
- `txd_overflow`  out  1  one-cycle pulse when a write is dropped because the FIFO is full.
- `txd`  out  1  serial line; idles high.

## Operation
- **FIFO**
  - Circular buffer with write pointer, read pointer and `count` (width log2(fifo_depth)+1).
  - `txd_full` = (`count`==fifo_depth). Both flags are taken from the registered `count`.
  - A write with `txd_full`=1 is dropped and `txd_overflow` pulses on the next cycle. This applies even if a pop happens in the same cycle.
  - A pop and an accepted write in the same cycle leave `count` unchanged.
  - Pointers wrap modulo fifo_depth.
- **Baud tick**
  - Fractional accumulator. acc_width = ceil-log2(clk_freq/baud)+8.
  - The accumulator register is acc_width+1 bits.
  - inc = round(baud·2^acc_width / clk_freq).
  - Each cycle: acc <= acc[acc_width-1:0] + inc. The tick is acc[acc_width].
  - While the state is IDLE, acc is held at inc, so the first tick comes about one bit period after a frame starts.
- **State machine**: IDLE, START, DATA (3-bit index 0..7), STOP.
  - IDLE, FIFO non-empty: pop the head into the 8-bit shift register and go to START. `txd` is 0 from that edge.
  - START on tick: go to DATA with bit index 0 and `txd` = shreg[0].
  - DATA on tick: shift the register right. If index==7, go to STOP with `txd`=1; otherwise index+1 and `txd` = next bit.
  - STOP on tick:
    - FIFO non-empty: pop and go to START directly, with `txd`=0 on the same edge (no idle gap).
    - FIFO empty: go to IDLE.
- `txd` is registered (driven straight from a flop, glitch-free).
- `txd_busy` = (state≠IDLE) | (`count`≠0).
- Reset, including in the middle of a frame:
  - `txd`=1 on the next edge.
  - state IDLE, FIFO flushed (pointers and `count` 0).
  - `txd_full`=0, `txd_busy`=0, `txd_overflow`=0, acc=inc.
  - The partial frame is abandoned.

## Timing
- With the FIFO empty and state IDLE, a strobe at edge N gives `count`=1 after edge N.
- The pop occurs at edge N+1, so `txd` falls after edge N+1. Write-to-start-bit latency is 2 cycles.
- Each bit lasts floor or ceil of clk_freq/baud cycles. The accumulated error over a frame stays within ±1 cycle of 10·clk_freq/baud.
- The frame is 10 bit periods: start, d0..d7, stop.
- Consecutive FIFO bytes follow with zero idle cycles between one stop bit and the next start bit.
- `txd_full` is updated one cycle after the accepted write that fills the FIFO. A write in that same cycle is still checked against the old value.

## Test plan
- **Reset values**: hold `rst_n`=0 for 5 cycles -> `txd`=1, `txd_busy`=0, `txd_full`=0, `txd_overflow`=0.
- **Single byte** (clk_freq=1000000, baud=100000): push 0xA5 -> `txd` low 2 cycles after the strobe.
  - Line bits are 0,1,0,1,0,0,1,0,1,1, each 10±1 cycles.
  - `txd_busy` drops within 1 cycle after the stop bit ends.
- **Back-to-back**: push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous frames, 300±3 cycles total, no idle high between a stop bit and the next start bit.
- **Full/overflow** (fifo_depth=4): push 6 bytes 0x10..0x15 on consecutive cycles.
  - 0x10 is popped at once, so 0x11..0x14 fill the FIFO and `txd_full`=1.
  - 0x15 is dropped with a single `txd_overflow` pulse.
  - Line output is 0x10..0x14 only.
- **Boundary**: push while full in the same cycle as the STOP→START pop -> write dropped, `txd_overflow` pulses, `count` decrements by 1.
- **Mid-frame reset**: assert `rst_n`=0 during data bit 3 of 0x3C -> `txd`=1 next cycle and FIFO empty. After release, push 0x81 -> a clean 0x81 frame with 2-cycle latency.
